// File: rtl/prog_launch_ctrl.sv
// prog_launch_ctrl: turns Start pulses into PC launches of a fixed program series,
// stops fetch on Halt or watchdog timeout and reports Done plus per-program cycle count.
module prog_launch_ctrl #(
  parameter int A       = 10,
  parameter int NPROG   = 3,
  parameter int BASE1   = 0,
  parameter int BASE2   = 400,
  parameter int BASE3   = 800,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  output logic          PcLoad,
  output logic [A-1:0]  PcTarget,
  output logic          PcHold,
  output logic          Done,
  output logic          Finished,
  output logic [1:0]    ProgNum,
  output logic [CW-1:0] CycleCount,
  output logic          TimeoutErr,
  output logic          StartErr
);

  // state    | meaning
  // IDLE     | waiting for the first Start rise
  // ARMED    | Start seen high, waiting for it to fall
  // LAUNCH   | one-cycle PC load of the program base
  // RUN      | fetch running, cycle counter advancing
  // DONE     | program stopped, waiting for next Start
  // FINISHED | whole series complete, only Reset leaves
  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_LAUNCH, S_RUN, S_DONE, S_FINISHED
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_start;
  logic [1:0]      r_prog_num;
  logic [CW-1:0]   r_cycle_cnt;
  logic            r_timeout_err;
  logic            r_start_err;

  logic            w_rise, w_fall, w_wd_hit;
  logic            w_prog_inc, w_start_err_set;
  logic [A-1:0]    w_base;

  assign w_rise   = Start & ~r_start;
  assign w_fall   = ~Start & r_start;
  assign w_wd_hit = (r_cycle_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_prog_inc      = 1'b0;
    w_start_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_ARMED;
          w_prog_inc  = 1'b1;
        end
      end
      S_ARMED: begin
        w_start_err_set = w_rise;
        if (w_fall) w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_start_err_set = w_rise;
        w_state_nxt     = S_RUN;
      end
      S_RUN: begin
        w_start_err_set = w_rise;
        if (Halt || w_wd_hit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (r_prog_num == 2'(NPROG)) begin
          w_state_nxt = S_FINISHED;
        end else if (w_rise) begin
          w_state_nxt = S_ARMED;
          w_prog_inc  = 1'b1;
        end
      end
      S_FINISHED: w_state_nxt = S_FINISHED;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_start       <= 1'b0;
      r_prog_num    <= '0;
      r_cycle_cnt   <= '0;
      r_timeout_err <= 1'b0;
      r_start_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= Start;
      if (w_prog_inc) r_prog_num <= r_prog_num + 2'd1;
      if (w_start_err_set) r_start_err <= 1'b1;
      if (r_state == S_LAUNCH) begin
        r_cycle_cnt   <= '0;
        r_timeout_err <= 1'b0;
      end else if (r_state == S_RUN) begin
        // Halt wins over a watchdog hit in the same cycle
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
        if (!Halt && w_wd_hit) r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    case (r_prog_num)
      2'd1:    w_base = A'(BASE1);
      2'd2:    w_base = A'(BASE2);
      2'd3:    w_base = A'(BASE3);
      default: w_base = '0;
    endcase
  end

  assign PcLoad     = (r_state == S_LAUNCH);
  assign PcTarget   = PcLoad ? w_base : '0;
  assign PcHold     = !((r_state == S_LAUNCH) || (r_state == S_RUN));
  assign Done       = (r_state == S_DONE) || (r_state == S_FINISHED);
  assign Finished   = (r_state == S_FINISHED);
  assign ProgNum    = r_prog_num;
  assign CycleCount = r_cycle_cnt;
  assign TimeoutErr = r_timeout_err;
  assign StartErr   = r_start_err;

endmodule

// File: tb/tb_prog_launch_ctrl.sv
// Directed bench for prog_launch_ctrl: table of {inputs, cycles, expected outputs}
// followed by a bounded launch-to-Done latency sequence.
module tb_prog_launch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start, Halt;
  logic        PcLoad, PcHold, Done, Finished, TimeoutErr, StartErr;
  logic [9:0]  PcTarget;
  logic [1:0]  ProgNum;
  logic [15:0] CycleCount;

  int total = 0;
  int bad   = 0;

  prog_launch_ctrl #(.TIMEOUT(50)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .PcLoad(PcLoad), .PcTarget(PcTarget), .PcHold(PcHold), .Done(Done),
    .Finished(Finished), .ProgNum(ProgNum), .CycleCount(CycleCount),
    .TimeoutErr(TimeoutErr), .StartErr(StartErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, start, halt;
    int          ncyc;
    logic        load;
    logic [9:0]  tgt;
    logic        hold, done, fin;
    logic [1:0]  pn;
    logic [15:0] cc;
    logic        to, se;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, h, input int n, input logic ld, input int tg,
                     input logic hd, dn, fn, input int p, input int c, input logic t, e);
    vec_t v;
    v.rst = r; v.start = s; v.halt = h; v.ncyc = n;
    v.load = ld; v.tgt = 10'(tg); v.hold = hd; v.done = dn; v.fin = fn;
    v.pn = 2'(p); v.cc = 16'(c); v.to = t; v.se = e;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int loads, cyc;
    bit seen;
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0;

    //   rst s h  n   load tgt hold done fin pn  cc  to se
    // program 1: Start high 3 cycles, Halt in 20th RUN cycle
    add(1, 0, 0,  1,  0,   0,  1,   0,   0,  0,  0, 0, 0);
    add(0, 1, 0,  1,  0,   0,  1,   0,   0,  1,  0, 0, 0);
    add(0, 1, 0,  2,  0,   0,  1,   0,   0,  1,  0, 0, 0);
    add(0, 0, 0,  1,  1,   0,  0,   0,   0,  1,  0, 0, 0);
    add(0, 0, 0,  1,  0,   0,  0,   0,   0,  1,  0, 0, 0);
    add(0, 0, 0, 19,  0,   0,  0,   0,   0,  1, 19, 0, 0);
    add(0, 0, 1,  1,  0,   0,  1,   1,   0,  1, 20, 0, 0);
    add(0, 0, 1,  2,  0,   0,  1,   1,   0,  1, 20, 0, 0);
    // programs 2 and 3, then FINISHED ignores Start
    add(0, 1, 0,  1,  0,   0,  1,   0,   0,  2, 20, 0, 0);
    add(0, 0, 0,  1,  1, 400,  0,   0,   0,  2, 20, 0, 0);
    add(0, 0, 0,  1,  0,   0,  0,   0,   0,  2,  0, 0, 0);
    add(0, 0, 0,  4,  0,   0,  0,   0,   0,  2,  4, 0, 0);
    add(0, 0, 1,  1,  0,   0,  1,   1,   0,  2,  5, 0, 0);
    add(0, 1, 0,  1,  0,   0,  1,   0,   0,  3,  5, 0, 0);
    add(0, 0, 0,  1,  1, 800,  0,   0,   0,  3,  5, 0, 0);
    add(0, 0, 0,  1,  0,   0,  0,   0,   0,  3,  0, 0, 0);
    add(0, 0, 1,  1,  0,   0,  1,   1,   0,  3,  1, 0, 0);
    add(0, 0, 0,  1,  0,   0,  1,   1,   1,  3,  1, 0, 0);
    add(0, 1, 0,  1,  0,   0,  1,   1,   1,  3,  1, 0, 0);
    add(0, 0, 0,  1,  0,   0,  1,   1,   1,  3,  1, 0, 0);
    add(0, 0, 0,  3,  0,   0,  1,   1,   1,  3,  1, 0, 0);
    // watchdog at 50 RUN cycles, then next launch clears TimeoutErr
    add(1, 0, 0,  1,  0,   0,  1,   0,   0,  0,  0, 0, 0);
    add(0, 1, 0,  1,  0,   0,  1,   0,   0,  1,  0, 0, 0);
    add(0, 0, 0,  1,  1,   0,  0,   0,   0,  1,  0, 0, 0);
    add(0, 0, 0,  1,  0,   0,  0,   0,   0,  1,  0, 0, 0);
    add(0, 0, 0, 49,  0,   0,  0,   0,   0,  1, 49, 0, 0);
    add(0, 0, 0,  1,  0,   0,  1,   1,   0,  1, 50, 1, 0);
    add(0, 0, 0,  2,  0,   0,  1,   1,   0,  1, 50, 1, 0);
    add(0, 1, 0,  1,  0,   0,  1,   0,   0,  2, 50, 1, 0);
    add(0, 0, 0,  1,  1, 400,  0,   0,   0,  2, 50, 1, 0);
    add(0, 0, 0,  1,  0,   0,  0,   0,   0,  2,  0, 0, 0);
    // Halt coincident with watchdog cycle
    add(0, 0, 0, 49,  0,   0,  0,   0,   0,  2, 49, 0, 0);
    add(0, 0, 1,  1,  0,   0,  1,   1,   0,  2, 50, 0, 0);
    // Start mid-RUN sets StartErr, then Reset mid-RUN
    add(0, 1, 0,  1,  0,   0,  1,   0,   0,  3, 50, 0, 0);
    add(0, 0, 0,  1,  1, 800,  0,   0,   0,  3, 50, 0, 0);
    add(0, 0, 0,  1,  0,   0,  0,   0,   0,  3,  0, 0, 0);
    add(0, 0, 0,  5,  0,   0,  0,   0,   0,  3,  5, 0, 0);
    add(0, 1, 0,  1,  0,   0,  0,   0,   0,  3,  6, 0, 1);
    add(0, 0, 0,  1,  0,   0,  0,   0,   0,  3,  7, 0, 1);
    add(0, 0, 0,  3,  0,   0,  0,   0,   0,  3, 10, 0, 1);
    add(1, 0, 0,  1,  0,   0,  1,   0,   0,  0,  0, 0, 0);
    // Start held high: stays ARMED, Halt ignored there
    add(0, 1, 0,  1,  0,   0,  1,   0,   0,  1,  0, 0, 0);
    add(0, 1, 0, 10,  0,   0,  1,   0,   0,  1,  0, 0, 0);
    add(0, 1, 1,  2,  0,   0,  1,   0,   0,  1,  0, 0, 0);

    foreach (vecs[i]) begin
      Reset = vecs[i].rst; Start = vecs[i].start; Halt = vecs[i].halt;
      repeat (vecs[i].ncyc) step();
      total++;
      if (PcLoad !== vecs[i].load || PcTarget !== vecs[i].tgt || PcHold !== vecs[i].hold ||
          Done !== vecs[i].done || Finished !== vecs[i].fin || ProgNum !== vecs[i].pn ||
          CycleCount !== vecs[i].cc || TimeoutErr !== vecs[i].to || StartErr !== vecs[i].se) begin
        bad++;
        $display("FAIL vec%0d: got load=%0d tgt=%0d hold=%0d done=%0d fin=%0d pn=%0d cc=%0d to=%0d se=%0d expected load=%0d tgt=%0d hold=%0d done=%0d fin=%0d pn=%0d cc=%0d to=%0d se=%0d",
                 i, PcLoad, PcTarget, PcHold, Done, Finished, ProgNum, CycleCount, TimeoutErr, StartErr,
                 vecs[i].load, vecs[i].tgt, vecs[i].hold, vecs[i].done, vecs[i].fin, vecs[i].pn,
                 vecs[i].cc, vecs[i].to, vecs[i].se);
      end
    end

    // Launch-to-Done latency with the watchdog: LAUNCH, RUN entry, then 50 RUN edges
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0;
    step();
    Reset = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    loads = 0; cyc = 0; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      step();
      cyc++;
      if (PcLoad) loads++;
      if (Done) seen = 1'b1;
    end
    check_bit("done_reached", seen, 1'b1);
    check_int("pcload_strobes", loads, 1);
    check_int("launch_to_done_cycles", cyc, 52);
    check_int("wd_cycle_count", int'(CycleCount), 50);
    check_bit("wd_timeout_err", TimeoutErr, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
